// File: rtl/cpu_pkg.sv
// Shared types for the cpu_core slice: opcodes, branch conditions, FSM states
// and instruction field positions.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_MOV = 4'd1,
        OP_NOT = 4'd2,
        OP_ADD = 4'd3,
        OP_SUB = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_SHR = 4'd8,
        OP_SHL = 4'd9,
        OP_ROL = 4'd10,
        OP_ASR = 4'd11,
        OP_LD  = 4'd12,
        OP_ST  = 4'd13,
        OP_BR  = 4'd14,
        OP_LDI = 4'd15
    } op_t;

    typedef enum logic [2:0] {
        BR_AL   = 3'd0,
        BR_Z    = 3'd1,
        BR_NZ   = 3'd2,
        BR_N    = 3'd3,
        BR_C    = 3'd4,
        BR_CALL = 3'd5,
        BR_RET  = 3'd6,
        BR_HALT = 3'd7
    } cond_t;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RA_HI  = 8;
    localparam int RA_LO  = 6;
    localparam int RB_HI  = 5;
    localparam int RB_LO  = 3;
    localparam int IMM_HI = 8;

    // Ops 1..11 go through the ALU and are the only ones that touch the flags.
    function automatic logic is_alu(input op_t op);
        return (op >= OP_MOV) && (op <= OP_ASR);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for cpu_core: result plus Z/N/C for ops MOV..ASR.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DW = 16
) (
    input  op_t           op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          z,
    output logic          n,
    output logic          c
);

    always_comb begin
        result = '0;
        c      = 1'b0;
        case (op)
            OP_MOV: result = a;
            OP_NOT: result = ~a;
            OP_ADD: {c, result} = {1'b0, a} + {1'b0, b};
            // c is the borrow out of the subtraction
            OP_SUB: {c, result} = {1'b0, a} - {1'b0, b};
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHR: begin
                result = {1'b0, a[DW-1:1]};
                c      = a[0];
            end
            OP_SHL: begin
                result = {a[DW-2:0], 1'b0};
                c      = a[DW-1];
            end
            OP_ROL: begin
                result = {a[DW-2:0], a[DW-1]};
                c      = a[DW-1];
            end
            OP_ASR: begin
                result = {a[DW-1], a[DW-1:1]};
                c      = a[0];
            end
            default: begin
                result = '0;
                c      = 1'b0;
            end
        endcase
        z = (result == '0);
        n = result[DW-1];
    end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle 8-register CPU core with a single request/ack memory port.
// Optional CALL/RET branch conditions are built when CPU_CORE_CALL_EN is defined.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int             DW       = 16,
    parameter int             AW       = 12,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          CLK_n,
    input  logic          RST,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_req,
    output logic          mem_we,
    input  logic          mem_ack,
    output logic          halted,
    output logic [AW-1:0] dbg_pc,
    output state_t        dbg_state,
    output logic [2:0]    dbg_flags
);

    // Memory handshake: mem_req/mem_addr/mem_we/mem_wdata are registered and held
    // stable until a cycle with mem_req && mem_ack; that rising edge completes the
    // transaction (read data sampled there) and the next request may start at once.

    state_t        state;
    logic [AW-1:0] pc;
    logic [15:0]   inst;
    logic [DW-1:0] regs [8];
    logic          fz, fn, fc;
`ifdef CPU_CORE_CALL_EN
    logic [AW-1:0] sp;
`endif

    op_t           op;
    cond_t         cond;
    logic [2:0]    rd, ra, rb;
    logic [DW-1:0] a_val, b_val;
    logic [DW-1:0] alu_res;
    logic          alu_z, alu_n, alu_c;
    logic          taken;
    logic          unused_inst;

    assign op          = op_t'(inst[OP_HI:OP_LO]);
    assign cond        = cond_t'(inst[RD_HI:RD_LO]);
    assign rd          = inst[RD_HI:RD_LO];
    assign ra          = inst[RA_HI:RA_LO];
    assign rb          = inst[RB_HI:RB_LO];
    assign a_val       = regs[ra];
    assign b_val       = regs[rb];
    assign unused_inst = ^inst[RB_LO-1:0];

    assign dbg_pc      = pc;
    assign dbg_state   = state;
    assign dbg_flags   = {fz, fn, fc};

    cpu_alu #(.DW(DW)) u_alu (
        .op     (op),
        .a      (a_val),
        .b      (b_val),
        .result (alu_res),
        .z      (alu_z),
        .n      (alu_n),
        .c      (alu_c)
    );

    always_comb begin
        taken = 1'b0;
        case (cond)
            BR_AL:   taken = 1'b1;
            BR_Z:    taken = fz;
            BR_NZ:   taken = ~fz;
            BR_N:    taken = fn;
            BR_C:    taken = fc;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge CLK_n) begin
        if (RST) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            inst      <= '0;
            fz        <= 1'b0;
            fn        <= 1'b0;
            fc        <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= RESET_PC;
            mem_wdata <= '0;
            halted    <= 1'b0;
`ifdef CPU_CORE_CALL_EN
            sp        <= '0;
`endif
        end else begin
            case (state)
                ST_FETCH: begin
                    // mem_req is low here only on the first cycle out of reset
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ack) begin
                        inst    <= mem_rdata[15:0];
                        pc      <= pc + 1'b1;
                        mem_req <= 1'b0;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state    <= ST_FETCH;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc;
                    if (is_alu(op)) begin
                        regs[rd] <= alu_res;
                        fz       <= alu_z;
                        fn       <= alu_n;
                        fc       <= alu_c;
                    end
                    case (op)
                        OP_LDI: regs[rd] <= DW'(inst[IMM_HI:0]);
                        OP_LD: begin
                            state    <= ST_MEM;
                            mem_addr <= a_val[AW-1:0];
                        end
                        OP_ST: begin
                            state     <= ST_MEM;
                            mem_addr  <= a_val[AW-1:0];
                            mem_we    <= 1'b1;
                            mem_wdata <= b_val;
                        end
                        OP_BR: begin
                            case (cond)
                                BR_HALT: begin
                                    state   <= ST_HALT;
                                    mem_req <= 1'b0;
                                    halted  <= 1'b1;
                                end
`ifdef CPU_CORE_CALL_EN
                                BR_CALL: begin
                                    // pc already points past the CALL: that is the return address
                                    state     <= ST_MEM;
                                    sp        <= sp - 1'b1;
                                    mem_addr  <= sp - 1'b1;
                                    mem_we    <= 1'b1;
                                    mem_wdata <= DW'(pc);
                                    pc        <= a_val[AW-1:0];
                                end
                                BR_RET: begin
                                    state    <= ST_MEM;
                                    mem_addr <= sp;
                                end
`endif
                                default: begin
                                    if (taken) begin
                                        pc       <= a_val[AW-1:0];
                                        mem_addr <= a_val[AW-1:0];
                                    end
                                end
                            endcase
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        state    <= ST_FETCH;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                        if (op == OP_LD) regs[rd] <= mem_rdata;
`ifdef CPU_CORE_CALL_EN
                        if (op == OP_BR && cond == BR_RET) begin
                            pc       <= mem_rdata[AW-1:0];
                            mem_addr <= mem_rdata[AW-1:0];
                            sp       <= sp + 1'b1;
                        end
`endif
                    end
                end
                ST_HALT: begin
                    mem_req <= 1'b0;
                    halted  <= 1'b1;
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: table-driven ALU vectors plus hand-written
// multi-cycle sequences (latency, branches, wait states, wrap, reset, halt).
module tb_cpu_core;
    import cpu_pkg::*;

    localparam int DW = 16;
    localparam int AW = 12;

    logic          CLK_n = 1'b0;
    logic          RST   = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_req;
    logic          mem_we;
    logic          mem_ack;
    logic          halted;
    logic [AW-1:0] dbg_pc;
    state_t        dbg_state;
    logic [2:0]    dbg_flags;

    cpu_core #(.DW(DW), .AW(AW), .RESET_PC(12'h000)) dut (
        .CLK_n     (CLK_n),
        .RST       (RST),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_ack   (mem_ack),
        .halted    (halted),
        .dbg_pc    (dbg_pc),
        .dbg_state (dbg_state),
        .dbg_flags (dbg_flags)
    );

    always #5 CLK_n = ~CLK_n;

    // ---------------- memory model ----------------
    logic [15:0]   img [4096];
    logic [15:0]   mem [4096];
    int            wait_cycles = 0;
    int            wcnt;
    int            cyc;
    int            st_count, st_cyc, fetch_count;
    logic [AW-1:0] st_addr, fetch_last, fetch_prev;
    logic [DW-1:0] st_data;

    assign mem_ack   = mem_req && (wcnt >= wait_cycles);
    assign mem_rdata = mem_ack ? mem[mem_addr] : 16'hDEAD;

    always @(posedge CLK_n) begin
        if (RST) begin
            mem         <= img;
            wcnt        <= 0;
            cyc         <= 0;
            st_count    <= 0;
            st_cyc      <= 0;
            fetch_count <= 0;
            st_addr     <= '0;
            st_data     <= '0;
            fetch_last  <= '0;
            fetch_prev  <= '0;
        end else begin
            cyc <= cyc + 1;
            if (mem_req && mem_ack) begin
                wcnt <= 0;
                if (mem_we) begin
                    mem[mem_addr] <= mem_wdata;
                    st_addr       <= mem_addr;
                    st_data       <= mem_wdata;
                    st_cyc        <= cyc;
                    st_count      <= st_count + 1;
                end else if (dbg_state == ST_FETCH) begin
                    fetch_prev  <= fetch_last;
                    fetch_last  <= mem_addr;
                    fetch_count <= fetch_count + 1;
                end
            end else if (mem_req) begin
                wcnt <= wcnt + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, rb, 3'b000};
    endfunction
    function automatic logic [15:0] i_ldi(input logic [2:0] rd, input logic [8:0] imm);
        return {4'hF, rd, imm};
    endfunction
    function automatic logic [15:0] i_ld(input logic [2:0] rd, input logic [2:0] ra);
        return enc(4'hC, rd, ra, 3'd0);
    endfunction
    function automatic logic [15:0] i_st(input logic [2:0] ra, input logic [2:0] rb);
        return enc(4'hD, 3'd0, ra, rb);
    endfunction
    function automatic logic [15:0] i_br(input logic [2:0] cond, input logic [2:0] ra);
        return enc(4'hE, cond, ra, 3'd0);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_img();
        for (int i = 0; i < 4096; i++) img[i] = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge CLK_n);
        RST = 1'b1;
        repeat (3) @(negedge CLK_n);
        RST = 1'b0;
    endtask

    task automatic run_to_halt(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge CLK_n);
            if (halted) break;
        end
        check({name, "_halted"}, {31'd0, halted}, 32'd1);
    endtask

    task automatic wait_state(input state_t s, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge CLK_n);
            if (dbg_state == s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [2:0]  flg;   // {Z, N, C}
        string       name;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n_mem;
        bit stable;

        vecs[0]  = '{4'd3,  16'h0005, 16'h0003, 16'h0008, 3'b000, "add"};
        vecs[1]  = '{4'd3,  16'hFFFF, 16'h0001, 16'h0000, 3'b101, "add_carry"};
        vecs[2]  = '{4'd4,  16'h0005, 16'h0005, 16'h0000, 3'b100, "sub_zero"};
        vecs[3]  = '{4'd4,  16'h0003, 16'h0005, 16'hFFFE, 3'b011, "sub_borrow"};
        vecs[4]  = '{4'd5,  16'hF0F0, 16'h3C3C, 16'h3030, 3'b000, "and"};
        vecs[5]  = '{4'd6,  16'h00F0, 16'h0F00, 16'h0FF0, 3'b000, "or"};
        vecs[6]  = '{4'd7,  16'hAAAA, 16'hAAAA, 16'h0000, 3'b100, "xor"};
        vecs[7]  = '{4'd2,  16'h00FF, 16'h1111, 16'hFF00, 3'b010, "not"};
        vecs[8]  = '{4'd8,  16'h0003, 16'h0000, 16'h0001, 3'b001, "shr"};
        vecs[9]  = '{4'd9,  16'h8001, 16'h0000, 16'h0002, 3'b001, "shl"};
        vecs[10] = '{4'd10, 16'h8000, 16'h0000, 16'h0001, 3'b001, "rol"};
        vecs[11] = '{4'd11, 16'h8002, 16'h0000, 16'hC001, 3'b010, "asr_neg"};
        vecs[12] = '{4'd1,  16'h1234, 16'hFFFF, 16'h1234, 3'b000, "mov"};
        vecs[13] = '{4'd11, 16'h0001, 16'h0000, 16'h0000, 3'b101, "asr_zero"};

        // ---- reset state and the basic four-instruction program ----
        wait_cycles = 0;
        clear_img();
        img[0] = i_ldi(3'd1, 9'd5);
        img[1] = i_ldi(3'd2, 9'd3);
        img[2] = enc(4'd3, 3'd3, 3'd1, 3'd2);
        img[3] = i_st(3'd0, 3'd3);
        img[4] = i_br(3'd7, 3'd0);
        @(negedge CLK_n);
        RST = 1'b1;
        repeat (3) @(negedge CLK_n);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_pc", {20'd0, dbg_pc}, 32'h000);
        check("rst_flags", {29'd0, dbg_flags}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, ST_FETCH});
        RST = 1'b0;
        @(negedge CLK_n);
        check("first_fetch_req", {31'd0, mem_req}, 32'd1);
        check("first_fetch_addr", {20'd0, mem_addr}, 32'h000);
        run_to_halt("basic", 100);
        check("basic_mem0", {16'd0, mem[0]}, 32'h0008);
        check("basic_cycles", st_cyc, 32'd9);
        check("basic_flags", {29'd0, dbg_flags}, 32'b000);

        // ---- ALU vectors ----
        for (int i = 0; i < 14; i++) begin
            clear_img();
            img[0]     = i_ldi(3'd7, 9'h100);
            img[1]     = i_ld(3'd1, 3'd7);
            img[2]     = i_ldi(3'd7, 9'h101);
            img[3]     = i_ld(3'd2, 3'd7);
            img[4]     = enc(vecs[i].op, 3'd3, 3'd1, 3'd2);
            img[5]     = i_ldi(3'd7, 9'h102);
            img[6]     = i_st(3'd7, 3'd3);
            img[7]     = i_br(3'd7, 3'd0);
            img[12'h100] = vecs[i].a;
            img[12'h101] = vecs[i].b;
            exp_q.push_back(vecs[i].res);
            do_reset();
            run_to_halt(vecs[i].name, 100);
            check({vecs[i].name, "_res"}, {16'd0, st_data}, {16'd0, exp_q.pop_front()});
            check({vecs[i].name, "_flags"}, {29'd0, dbg_flags}, {29'd0, vecs[i].flg});
        end

        // ---- SUB to zero, untaken BR C, taken BR Z ----
        clear_img();
        img[0]     = i_ldi(3'd1, 9'd5);
        img[1]     = enc(4'd4, 3'd3, 3'd1, 3'd1);
        img[2]     = i_ldi(3'd4, 9'h020);
        img[3]     = i_br(3'd4, 3'd4);
        img[4]     = i_br(3'd1, 3'd4);
        img[12'h020] = i_st(3'd0, 3'd3);
        img[12'h021] = i_br(3'd7, 3'd0);
        do_reset();
        run_to_halt("branch", 100);
        check("branch_target_fetch", {20'd0, fetch_prev}, 32'h020);
        check("branch_last_fetch", {20'd0, fetch_last}, 32'h021);
        check("branch_fetch_count", fetch_count, 32'd7);
        check("sub_zero_store", {16'd0, mem[0]}, 32'h0000);
        check("branch_flags", {29'd0, dbg_flags}, 32'b100);

        // ---- LD with three wait cycles ----
        wait_cycles = 3;
        clear_img();
        img[0]     = i_ldi(3'd1, 9'h055);
        img[1]     = i_ldi(3'd7, 9'h100);
        img[2]     = i_ld(3'd1, 3'd7);
        img[3]     = i_st(3'd0, 3'd1);
        img[4]     = i_br(3'd7, 3'd0);
        img[12'h100] = 16'h4321;
        do_reset();
        wait_state(ST_MEM, 100, ok);
        check("ld_wait_reach_mem", {31'd0, ok}, 32'd1);
        n_mem  = 0;
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (dbg_state != ST_MEM) break;
            n_mem++;
            if (!(mem_req && !mem_we && mem_addr == 12'h100)) stable = 1'b0;
            @(negedge CLK_n);
        end
        check("ld_wait_len", n_mem, 32'd4);
        check("ld_wait_stable", {31'd0, stable}, 32'd1);
        run_to_halt("ld_wait", 200);
        check("ld_wait_data", {16'd0, st_data}, 32'h4321);

        // ---- pc wraps from 0xFFF to 0x000 ----
        wait_cycles = 0;
        clear_img();
        img[0]     = i_ldi(3'd7, 9'h100);
        img[1]     = i_ld(3'd4, 3'd7);
        img[2]     = i_br(3'd0, 3'd4);
        img[12'h100] = 16'h0FFF;
        do_reset();
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK_n);
            if (fetch_count >= 5) break;
        end
        check("wrap_seen", {31'd0, fetch_count >= 5}, 32'd1);
        check("wrap_prev", {20'd0, fetch_prev}, 32'hFFF);
        check("wrap_next", {20'd0, fetch_last}, 32'h000);

        // ---- reset in the middle of a waiting LD ----
        wait_cycles = 3;
        clear_img();
        img[0]     = i_ldi(3'd7, 9'h100);
        img[1]     = i_ld(3'd1, 3'd7);
        img[2]     = i_br(3'd7, 3'd0);
        do_reset();
        wait_state(ST_MEM, 100, ok);
        check("rst_mid_ld_reach_mem", {31'd0, ok}, 32'd1);
        RST = 1'b1;
        @(negedge CLK_n);
        check("rst_mid_ld_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_ld_pc", {20'd0, dbg_pc}, 32'h000);
        RST = 1'b0;
        @(negedge CLK_n);
        check("rst_resume_req", {31'd0, mem_req}, 32'd1);
        check("rst_resume_addr", {20'd0, mem_addr}, 32'h000);
        run_to_halt("rst_resume", 200);

`ifdef CPU_CORE_CALL_EN
        // ---- CALL / RET / CALL: sp must come back to 0 ----
        wait_cycles = 0;
        clear_img();
        img[0]     = i_ldi(3'd4, 9'h010);
        img[1]     = i_ldi(3'd5, 9'h040);
        img[2]     = i_ldi(3'd6, 9'h050);
        img[3]     = i_br(3'd0, 3'd4);
        img[12'h010] = i_br(3'd5, 3'd5);
        img[12'h040] = i_br(3'd6, 3'd0);
        img[12'h011] = i_br(3'd5, 3'd6);
        img[12'h050] = i_br(3'd7, 3'd0);
        do_reset();
        run_to_halt("call", 200);
        check("call_ret_addr_word", {16'd0, mem[12'hFFF]}, 32'h0012);
        check("call_store_count", st_count, 32'd2);
        check("call_sp_restored", {20'd0, st_addr}, 32'hFFF);
        check("ret_fetch", {20'd0, fetch_prev}, 32'h011);
        check("call2_fetch", {20'd0, fetch_last}, 32'h050);
`else
        // ---- cond 5/6 behave as NOP when CALL/RET are not built ----
        wait_cycles = 0;
        clear_img();
        img[0] = i_ldi(3'd4, 9'h030);
        img[1] = i_br(3'd5, 3'd4);
        img[2] = i_br(3'd6, 3'd4);
        img[3] = i_st(3'd0, 3'd4);
        img[4] = i_br(3'd7, 3'd0);
        do_reset();
        run_to_halt("call_nop", 100);
        check("call_nop_store_count", st_count, 32'd1);
        check("call_nop_store_data", {16'd0, st_data}, 32'h0030);
        check("call_nop_last_fetch", {20'd0, fetch_last}, 32'h004);
        check("call_nop_cycles", st_cyc, 32'd9);
`endif

        // ---- HALT holds: no requests, halted stays high ----
        stable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK_n);
            if (mem_req || !halted) stable = 1'b0;
        end
        check("halt_quiet", {31'd0, stable}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 Parameter DW, default 16, data/register width; SHALL be >= 16.
REQ-002 Parameter AW, default 12, memory word-address width; SHALL be <= DW.
REQ-003 Parameter RESET_PC, default 0, AW-bit fetch address after reset.
REQ-004 CLK_n  input  1  single clock; all state updates on its rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 mem_addr  output  AW  word address of the current memory transaction.
REQ-007 mem_wdata  output  DW  store data, valid while mem_req && mem_we.
REQ-008 mem_rdata  input  DW  read data, sampled on the edge where mem_req && mem_ack.
REQ-009 mem_req  output  1  transaction request; held with addr/we/wdata stable until acked.
REQ-010 mem_we  output  1  1 = write, 0 = read; meaningful only with mem_req.
REQ-011 mem_ack  input  1  completion; may assert in the same cycle as mem_req (zero wait).
REQ-012 halted  output  1  core is in HALT.
REQ-013 dbg_pc  output  AW  current program counter.

Function
REQ-014 Instruction word: inst[15:12] op, [11:9] rd/cond, [8:6] ra, [5:3] rb; the low 16 bits of mem_rdata are used; 8 registers r0..r7, all writable.
REQ-015 Ops: 0 NOP, 1 MOV rd=ra, 2 NOT, 3 ADD, 4 SUB ra-rb, 5 AND, 6 OR, 7 XOR, 8 SHR logical, 9 SHL, 10 ROL, 11 ASR (shifts by 1 over full DW), 12 LD rd=mem[ra], 13 ST mem[ra]=rb, 14 BR, 15 LDI rd = zero-extended inst[8:0].
REQ-016 Addresses from registers use bits [AW-1:0]; pc and sp wrap modulo 2^AW.
REQ-017 Flags Z, N, C are updated only by ops 1-11: Z = result==0, N = result[DW-1], C = ADD carry-out, SUB borrow, shifted-out bit for 8-11, 0 otherwise.
REQ-018 BR cond (inst[11:9]): 0 always, 1 Z, 2 !Z, 3 N, 4 C; taken branch sets pc = ra[AW-1:0]; not taken falls through; 5/6 per REQ-027; 7 HALT.
REQ-019 States: FETCH, EXEC, MEM, HALT.
REQ-020 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on ack latch inst, pc <= pc+1, go to EXEC; otherwise stay.
REQ-021 EXEC: ops 0-11, 15, BR write back in one cycle and go to FETCH; LD, ST (and CALL/RET) go to MEM; HALT goes to HALT.
REQ-022 MEM: single transaction held until ack; LD writes rd on the ack edge; then FETCH.
REQ-023 Latency with zero-wait memory: ALU/LDI/BR = 2 cycles, LD/ST = 3 cycles; each wait cycle adds 1.
REQ-024 HALT: mem_req=0, halted=1; exited only by RST.
REQ-025 mem_req SHALL NOT deassert before ack once raised, except by RST.

Reset
REQ-026 While RST=1 the core SHALL: set state FETCH, pc=RESET_PC, sp=0, flags=0, r0..r7=0; drive mem_req=0, mem_we=0, halted=0. Any in-flight transaction is abandoned; fetch starts the cycle after RST falls.

Configuration
REQ-027 With CPU_CORE_CALL_EN defined: cond 5 CALL (sp <= sp-1, write pc to mem[sp-1] in MEM, pc=ra) and cond 6 RET (read mem[sp] in MEM, pc = data[AW-1:0], sp <= sp+1) are enabled. Without the macro: cond 5/6 execute as NOP, sp is not built, and there are no MEM visits for these conds.

Structure
REQ-028 Package cpu_pkg holds the opcode enum, BR condition enum, state enum and instruction field positions.
REQ-029 Sub-module cpu_alu (combinational, DW-parametrised) computes result and Z/N/C; the register array and FSM live in cpu_core.

Verification
REQ-030 Reset then LDI r1,5; LDI r2,3; ADD r3,r1,r2; ST [r0],r3 with zero wait -> mem[0]=8, Z=0, C=0, cycle count 2+2+2+3.
REQ-031 SUB r3,r1,r1 with r1=5 -> r3=0, Z=1, C=0; BR cond 1 to r4=0x20 -> next fetch address 0x020.
REQ-032 ADD with 0xFFFF+1 (DW=16) -> result 0, Z=1, C=1; ROL of 0x8000 -> 0x0001, C=1.
REQ-033 LD with 3 wait cycles (ack late) -> mem_req/addr stable 4 cycles, rd written on the ack edge only.
REQ-034 pc=0xFFF (AW=12) fetch -> next fetch at 0x000; RST asserted mid-LD -> mem_req=0 next cycle, fetch resumes at RESET_PC.
REQ-035 CPU_CORE_CALL_EN: CALL from pc 0x010 with sp=0 -> write 0x011 to 0xFFF, RET -> pc 0x011, sp 0; HALT -> halted=1, mem_req stays 0.
